// File: rtl/matrix_pkg.sv
// Shared constants, types and the feeder state encoding for the 4x4 matrix
// feeder. Matrices are packed [0:15], element index 4*row+col.
package matrix_pkg;

    localparam int MAT_N     = 4;
    localparam int MAT_ELEMS = 16;
    localparam int ELEM_W    = 12;

    typedef logic [ELEM_W-1:0]          elem_t;
    typedef elem_t [0:MAT_ELEMS-1]      mat_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_SYNC     = 3'd2,
        ST_LEAD     = 3'd3,
        ST_STREAM   = 3'd4,
        ST_WAIT_RES = 3'd5,
        ST_HOLD     = 3'd6
    } feeder_state_e;

    // Beat counter to element index: column-major walk, so the low counter
    // bits select the row and the high bits the column.
    function automatic logic [3:0] col_major_idx(input logic [3:0] cnt);
        return {cnt[1:0], cnt[3:2]};
    endfunction

endpackage

// File: rtl/matrix_col_serializer.sv
// Registered index mux: turns the latched A/B matrices plus a beat count into
// one element pair per cycle in column-major order. Outputs are zero when no
// beat is due (including the lead cycle).
module matrix_col_serializer
    import matrix_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [0:MAT_ELEMS-1][DATA_W-1:0] i_a,
    input  logic [0:MAT_ELEMS-1][DATA_W-1:0] i_b,
    input  logic                           i_en,
    input  logic [3:0]                     i_cnt,
    output logic [DATA_W-1:0]              o_a,
    output logic [DATA_W-1:0]              o_b
);

    logic [3:0]        w_idx;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;

    assign w_idx = col_major_idx(i_cnt);

    // Register the selected element pair, or zeros when no beat is due.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_en) begin
            r_a <= i_a[w_idx];
            r_b <= i_b[w_idx];
        end else begin
            r_a <= '0;
            r_b <= '0;
        end
    end

    assign o_a = r_a;
    assign o_b = r_b;

endmodule

// File: rtl/matrix_4x4_feeder.sv
// Host-side driver for the 4x4 matrix multiplier. Accepts A/B from the host,
// waits for the multiplier, streams the element pairs column-major, captures
// the four result columns and holds C row-major until the host takes it.
// Optional result watchdog: define MATRIX_4X4_FEEDER_TIMEOUT_EN to add the
// timeout_err port and abandon a job after TIMEOUT_CYCLES in WAIT_RES.
module matrix_4x4_feeder
    import matrix_pkg::*;
#(
    parameter int DATA_W         = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [0:MAT_ELEMS-1][DATA_W-1:0] s_a,
    input  logic [0:MAT_ELEMS-1][DATA_W-1:0] s_b,
    input  logic                             mm_ready_out,
    output logic                             mm_ready_in,
    output logic                             mm_valid_in,
    output logic [DATA_W-1:0]                mm_a,
    output logic [DATA_W-1:0]                mm_b,
    input  logic                             mm_valid_out,
    input  logic [0:MAT_N-1][DATA_W-1:0]     mm_cC1,
    input  logic [0:MAT_N-1][DATA_W-1:0]     mm_cC2,
    input  logic [0:MAT_N-1][DATA_W-1:0]     mm_cC3,
    input  logic [0:MAT_N-1][DATA_W-1:0]     mm_cC4,
    output logic                             m_c_valid,
    input  logic                             m_c_ready,
    output logic [0:MAT_ELEMS-1][DATA_W-1:0] m_c,
    output logic                             busy
`ifdef MATRIX_4X4_FEEDER_TIMEOUT_EN
    ,
    output logic                             timeout_err
`endif
);

    feeder_state_e                    r_state;
    feeder_state_e                    w_state_nxt;
    logic [3:0]                       r_cnt;
    logic [0:MAT_ELEMS-1][DATA_W-1:0] r_a;
    logic [0:MAT_ELEMS-1][DATA_W-1:0] r_b;
    logic [0:MAT_ELEMS-1][DATA_W-1:0] r_c;
    logic [0:MAT_ELEMS-1][DATA_W-1:0] w_c;
    logic                             r_s_ready;
    logic                             r_mm_ready_in;
    logic                             r_mm_valid_in;
    logic                             r_m_c_valid;
    logic                             r_busy;
    logic                             w_beat_en;
    logic [3:0]                       w_beat_cnt;

`ifdef MATRIX_4X4_FEEDER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;
    logic            w_to_hit;
`endif

    // Result columns regrouped row-major: element 4*i+k comes from column k+1, row i.
    assign w_c = {mm_cC1[0], mm_cC2[0], mm_cC3[0], mm_cC4[0],
                  mm_cC1[1], mm_cC2[1], mm_cC3[1], mm_cC4[1],
                  mm_cC1[2], mm_cC2[2], mm_cC3[2], mm_cC4[2],
                  mm_cC1[3], mm_cC2[3], mm_cC3[3], mm_cC4[3]};

    // Next-state decision for the job sequencer.
    always_comb begin
        w_state_nxt = r_state;
`ifdef MATRIX_4X4_FEEDER_TIMEOUT_EN
        w_to_hit    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (s_valid && r_s_ready) begin
                    w_state_nxt = ST_WAIT_RDY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_RDY: begin
                if (mm_ready_out) begin
                    w_state_nxt = ST_SYNC;
                end else begin
                    w_state_nxt = ST_WAIT_RDY;
                end
            end
            ST_SYNC:   w_state_nxt = ST_LEAD;
            ST_LEAD:   w_state_nxt = ST_STREAM;
            ST_STREAM: begin
                if (r_cnt == 4'd15) begin
                    w_state_nxt = ST_WAIT_RES;
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_WAIT_RES: begin
                if (mm_valid_out) begin
                    w_state_nxt = ST_HOLD;
                end else begin
`ifdef MATRIX_4X4_FEEDER_TIMEOUT_EN
                    if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_to_hit    = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT_RES;
                    end
`else
                    w_state_nxt = ST_WAIT_RES;
`endif
                end
            end
            ST_HOLD: begin
                if (m_c_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Which beat the serializer must present after the coming edge: beat 0
    // follows the lead cycle, then one beat per streaming cycle up to 15.
    always_comb begin
        w_beat_en  = 1'b0;
        w_beat_cnt = 4'd0;
        if (r_state == ST_LEAD) begin
            w_beat_en  = 1'b1;
            w_beat_cnt = 4'd0;
        end else if ((r_state == ST_STREAM) && (r_cnt != 4'd15)) begin
            w_beat_en  = 1'b1;
            w_beat_cnt = r_cnt + 4'd1;
        end else begin
            w_beat_en  = 1'b0;
            w_beat_cnt = 4'd0;
        end
    end

    // Sequencer state, beat counter, operand/result registers and flags,
    // with every flag registered from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
            r_s_ready     <= 1'b0;
            r_mm_ready_in <= 1'b0;
            r_mm_valid_in <= 1'b0;
            r_m_c_valid   <= 1'b0;
            r_busy        <= 1'b0;
`ifdef MATRIX_4X4_FEEDER_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_s_ready     <= (w_state_nxt == ST_IDLE);
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_mm_ready_in <= (w_state_nxt == ST_SYNC);
            r_mm_valid_in <= (w_state_nxt == ST_LEAD) || (w_state_nxt == ST_STREAM);
            r_m_c_valid   <= (w_state_nxt == ST_HOLD);

            if ((r_state == ST_IDLE) && (w_state_nxt == ST_WAIT_RDY)) begin
                r_a <= s_a;
                r_b <= s_b;
            end

            if ((r_state == ST_STREAM) && (r_cnt != 4'd15)) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd0;
            end

            if ((r_state == ST_WAIT_RES) && mm_valid_out) begin
                r_c <= w_c;
            end

`ifdef MATRIX_4X4_FEEDER_TIMEOUT_EN
            if (r_state == ST_WAIT_RES) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
            r_timeout_err <= w_to_hit;
`endif
        end
    end

    matrix_col_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk   (clk),
        .rst   (rst),
        .i_a   (r_a),
        .i_b   (r_b),
        .i_en  (w_beat_en),
        .i_cnt (w_beat_cnt),
        .o_a   (mm_a),
        .o_b   (mm_b)
    );

    assign s_ready     = r_s_ready;
    assign mm_ready_in = r_mm_ready_in;
    assign mm_valid_in = r_mm_valid_in;
    assign m_c_valid   = r_m_c_valid;
    assign m_c         = r_c;
    assign busy        = r_busy;
`ifdef MATRIX_4X4_FEEDER_TIMEOUT_EN
    assign timeout_err = r_timeout_err;
`endif

endmodule
